// File: rtl/ysyx_dmem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ysyx_dmem_responder_if                                   |
// | Brief   : Request/response bundle between execute stage and dmem.  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface ysyx_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ysyx_dmem_responder                                      |
// | Brief   : Fixed-latency word SRAM slave with byte-strobed writes.  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module ysyx_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ysyx_dmem_responder_if.slave    bus
);

  localparam int          c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] c_BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] c_DEPTH     = 30'(DEPTH_WORDS);
  localparam logic [3:0]  c_LAT       = 4'(LATENCY);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic            r_wen;
  logic [c_AW-1:0] r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wmask;
  logic            r_in_range;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [29:0]     w_word;
  logic [29:0]     w_off;
  logic            w_in_range;
  logic            w_access;
  logic            w_commit;
  logic            w_unused_addr;

  // Word-granular range check; the lower-bound test keeps addresses below
  // the base from wrapping into the array.
  assign w_word        = bus.req_addr[31:2];
  assign w_off         = w_word - c_BASE_WORD;
  assign w_in_range    = (w_word >= c_BASE_WORD) && (w_off < c_DEPTH);
  assign w_unused_addr = &{1'b0, bus.req_addr[1:0]};

  assign w_access = (r_state == c_WAIT) && (r_cnt == 4'd1);
  assign w_commit = w_access && r_wen && r_in_range;

  assign bus.req_ready  = (r_state == c_IDLE);
  assign bus.resp_valid = (r_state == c_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= 4'd0;
      r_wen      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_wmask    <= 4'd0;
      r_in_range <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.req_valid) begin
            r_state    <= c_WAIT;
            r_cnt      <= c_LAT;
            r_wen      <= bus.req_wen;
            r_idx      <= w_off[c_AW-1:0];
            r_wdata    <= bus.req_wdata;
            r_wmask    <= bus.req_wmask;
            r_in_range <= w_in_range;
          end
        end
        c_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= c_RESP;
            r_cnt   <= 4'd0;
            r_err   <= !r_in_range;
            r_rdata <= (r_in_range && !r_wen) ? r_mem[r_idx] : 32'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_RESP: begin
          if (bus.resp_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // The array has no reset; a reset during WAIT drops the write because
  // the state register leaves WAIT before the commit edge.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wmask[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
